// File: rtl/game_pkg.sv
// Shared game constants and state encoding, also used by the per-lane note blocks.
package game_pkg;

    localparam int unsigned DEF_NUM_LANES    = 4;
    localparam int unsigned DEF_SCORE_W      = 16;
    localparam int unsigned DEF_COMBO_W      = 8;
    localparam int unsigned DEF_MULT_STEP    = 10;
    localparam int unsigned DEF_MAX_MULT     = 4;
    localparam int unsigned DEF_MAX_MISSES   = 8;
    localparam int unsigned DEF_LEVEL_POINTS = 50;
    localparam int unsigned DEF_SPEED_STEP   = 20000;
    localparam int unsigned DEF_SPEED_MAX    = 200000;

    localparam int unsigned MULT_W  = 3;
    localparam int unsigned MISS_W  = 4;
    localparam int unsigned SPEED_W = 50;

    typedef enum logic [1:0] {
        ST_TITLE = 2'b00,
        ST_PLAY  = 2'b01,
        ST_OVER  = 2'b10
    } game_state_t;

endpackage

// File: rtl/lane_event_counter.sv
// Per-lane miss edge detection and hit/miss popcounts for one cycle.
module lane_event_counter #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned CNT_W     = $clog2(NUM_LANES + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_LANES-1:0] point_flag,
    input  logic [NUM_LANES-1:0] block_gone_flag,
    output logic [CNT_W-1:0]     hits_c,
    output logic [CNT_W-1:0]     misses_c
);

    logic [NUM_LANES-1:0] prev_gone;

    // Miss flag history, tracked in every game state so stale levels never count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_gone <= '0;
        end else begin
            prev_gone <= block_gone_flag;
        end
    end

    // Count hit pulses and rising miss edges across all lanes.
    always_comb begin
        hits_c   = '0;
        misses_c = '0;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            hits_c   = hits_c + CNT_W'(point_flag[i]);
            misses_c = misses_c + CNT_W'(block_gone_flag[i] & ~prev_gone[i]);
        end
    end

endmodule

// File: rtl/score_tracker.sv
// Score, combo, multiplier, miss and difficulty tracking with the TITLE/PLAY/OVER game FSM.
module score_tracker
    import game_pkg::*;
#(
    parameter int unsigned NUM_LANES    = DEF_NUM_LANES,
    parameter int unsigned SCORE_W      = DEF_SCORE_W,
    parameter int unsigned COMBO_W      = DEF_COMBO_W,
    parameter int unsigned MULT_STEP    = DEF_MULT_STEP,
    parameter int unsigned MAX_MULT     = DEF_MAX_MULT,
    parameter int unsigned MAX_MISSES   = DEF_MAX_MISSES,
    parameter int unsigned LEVEL_POINTS = DEF_LEVEL_POINTS,
    parameter int unsigned SPEED_STEP   = DEF_SPEED_STEP,
    parameter int unsigned SPEED_MAX    = DEF_SPEED_MAX
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_switch,
    input  logic [NUM_LANES-1:0] point_flag,
    input  logic [NUM_LANES-1:0] block_gone_flag,
    output logic [1:0]           game_state,
    output logic [SCORE_W-1:0]   score,
    output logic [COMBO_W-1:0]   combo,
    output logic [MULT_W-1:0]    multiplier,
    output logic [MISS_W-1:0]    miss_count,
    output logic                 game_over,
    output logic [SPEED_W-1:0]   speed_shift
);

    localparam int unsigned CNT_W = $clog2(NUM_LANES + 1);
    localparam int unsigned AWD_W = CNT_W + MULT_W;
    localparam int unsigned ACC_W = $clog2(LEVEL_POINTS) + AWD_W;

    game_state_t          state, state_next;
    logic [CNT_W-1:0]     hits, misses;
    logic [ACC_W-1:0]     level_acc, acc_nx, acc_sum;
    logic [AWD_W-1:0]     awarded;
    logic [SCORE_W:0]     score_sum;
    logic [COMBO_W:0]     combo_sum;
    logic [COMBO_W-1:0]   combo_play, mult_idx;
    logic [MISS_W:0]      miss_sum;
    logic [MISS_W-1:0]    miss_play;
    logic [MULT_W-1:0]    mult_play;
    logic [SPEED_W-1:0]   speed_up;
    logic [SCORE_W-1:0]   score_nx;
    logic [COMBO_W-1:0]   combo_nx;
    logic [MULT_W-1:0]    mult_nx;
    logic [MISS_W-1:0]    miss_nx;
    logic [SPEED_W-1:0]   speed_nx;

    lane_event_counter #(
        .NUM_LANES (NUM_LANES),
        .CNT_W     (CNT_W)
    ) u_events (
        .clk             (clk),
        .reset           (reset),
        .point_flag      (point_flag),
        .block_gone_flag (block_gone_flag),
        .hits_c          (hits),
        .misses_c        (misses)
    );

    assign game_state = state;

    // Game state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_TITLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next counter values; PLAY updates use the pre-update multiplier.
    always_comb begin
        state_next = state;
        score_nx   = score;
        combo_nx   = combo;
        mult_nx    = multiplier;
        miss_nx    = miss_count;
        speed_nx   = speed_shift;
        acc_nx     = level_acc;

        awarded    = AWD_W'(hits) * AWD_W'(multiplier);
        score_sum  = (SCORE_W+1)'(score) + (SCORE_W+1)'(awarded);
        combo_sum  = (COMBO_W+1)'(combo) + (COMBO_W+1)'(hits);
        combo_play = (misses != '0) ? '0
                   : (combo_sum[COMBO_W] ? '1 : combo_sum[COMBO_W-1:0]);
        mult_idx   = combo_play / COMBO_W'(MULT_STEP);
        mult_play  = (mult_idx >= COMBO_W'(MAX_MULT - 1)) ? MULT_W'(MAX_MULT)
                   : MULT_W'(mult_idx) + MULT_W'(1);
        miss_sum   = (MISS_W+1)'(miss_count) + (MISS_W+1)'(misses);
        miss_play  = miss_sum[MISS_W] ? '1 : miss_sum[MISS_W-1:0];
        acc_sum    = level_acc + ACC_W'(awarded);
        speed_up   = (speed_shift >= SPEED_W'(SPEED_MAX - SPEED_STEP)) ? SPEED_W'(SPEED_MAX)
                   : speed_shift + SPEED_W'(SPEED_STEP);

        case (state)
            ST_TITLE: begin
                if (start_switch) begin
                    state_next = ST_PLAY;
                    score_nx   = '0;
                    combo_nx   = '0;
                    mult_nx    = MULT_W'(1);
                    miss_nx    = '0;
                    speed_nx   = '0;
                    acc_nx     = '0;
                end
            end
            ST_PLAY: begin
                score_nx = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                combo_nx = combo_play;
                mult_nx  = mult_play;
                miss_nx  = miss_play;
                if (acc_sum >= ACC_W'(LEVEL_POINTS)) begin
                    acc_nx   = acc_sum - ACC_W'(LEVEL_POINTS);
                    speed_nx = speed_up;
                end else begin
                    acc_nx   = acc_sum;
                end
                if (!start_switch) begin
                    state_next = ST_TITLE;
                end else if (miss_play >= MISS_W'(MAX_MISSES)) begin
                    state_next = ST_OVER;
                end
            end
            ST_OVER: begin
                if (!start_switch) begin
                    state_next = ST_TITLE;
                end
            end
            default: begin
                state_next = ST_TITLE;
            end
        endcase
    end

    // Registered counters and outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            score       <= '0;
            combo       <= '0;
            multiplier  <= MULT_W'(1);
            miss_count  <= '0;
            speed_shift <= '0;
            level_acc   <= '0;
            game_over   <= 1'b0;
        end else begin
            score       <= score_nx;
            combo       <= combo_nx;
            multiplier  <= mult_nx;
            miss_count  <= miss_nx;
            speed_shift <= speed_nx;
            level_acc   <= acc_nx;
            game_over   <= (state_next == ST_OVER);
        end
    end

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker: vector tables plus multi-cycle level and saturation sequences.
module tb_score_tracker;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_switch;
    logic [3:0]  point_flag;
    logic [3:0]  block_gone_flag;
    logic [1:0]  game_state;
    logic [15:0] score;
    logic [7:0]  combo;
    logic [2:0]  multiplier;
    logic [3:0]  miss_count;
    logic        game_over;
    logic [49:0] speed_shift;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] pf;
        logic [3:0] bg;
        int         score;
        int         combo;
        int         mult;
        int         miss;
        int         st;
        int         speed;
    } vec_t;

    vec_t vecs [24];
    vec_t lvl  [8];

    score_tracker dut (
        .clk             (clk),
        .reset           (reset),
        .start_switch    (start_switch),
        .point_flag      (point_flag),
        .block_gone_flag (block_gone_flag),
        .game_state      (game_state),
        .score           (score),
        .combo           (combo),
        .multiplier      (multiplier),
        .miss_count      (miss_count),
        .game_over       (game_over),
        .speed_shift     (speed_shift)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int e_score, input int e_combo, input int e_mult,
                             input int e_miss, input int e_st, input int e_speed);
        check({tag, " score"}, longint'(score), longint'(e_score));
        check({tag, " combo"}, longint'(combo), longint'(e_combo));
        check({tag, " mult"}, longint'(multiplier), longint'(e_mult));
        check({tag, " miss"}, longint'(miss_count), longint'(e_miss));
        check({tag, " state"}, longint'(game_state), longint'(e_st));
        check({tag, " game_over"}, longint'(game_over), longint'(e_st == 2));
        check({tag, " speed"}, longint'(speed_shift), longint'(e_speed));
    endtask

    // Drive one cycle of lane inputs and sample just after the clock edge.
    task automatic step(input logic [3:0] pf, input logic [3:0] bg);
        point_flag      = pf;
        block_gone_flag = bg;
        @(posedge clk);
        #1;
        point_flag = 4'b0000;
    endtask

    function automatic vec_t mk(input logic [3:0] pf, input logic [3:0] bg, input int s, input int c,
                                input int m, input int mi, input int st, input int sp);
        vec_t v;
        v.pf = pf; v.bg = bg; v.score = s; v.combo = c; v.mult = m;
        v.miss = mi; v.st = st; v.speed = sp;
        return v;
    endfunction

    initial begin
        // Single-lane hits: multiplier steps to 2 once combo reaches 10.
        for (int i = 0; i < 10; i++) begin
            vecs[i] = mk(4'b0001, 4'b0000, i + 1, i + 1, (i == 9) ? 2 : 1, 0, 1, 0);
        end
        vecs[10] = mk(4'b0001, 4'b0000, 12, 11, 2, 0, 1, 0);
        vecs[11] = mk(4'b0000, 4'b0001, 12,  0, 1, 1, 1, 0);
        vecs[12] = mk(4'b1111, 4'b0001, 16,  4, 1, 1, 1, 0);
        vecs[13] = mk(4'b1111, 4'b0101, 20,  0, 1, 2, 1, 0);
        vecs[14] = mk(4'b0000, 4'b0000, 20,  0, 1, 2, 1, 0);
        vecs[15] = mk(4'b0000, 4'b0010, 20,  0, 1, 3, 1, 0);
        vecs[16] = mk(4'b0000, 4'b0000, 20,  0, 1, 3, 1, 0);
        vecs[17] = mk(4'b0000, 4'b1000, 20,  0, 1, 4, 1, 0);
        vecs[18] = mk(4'b0000, 4'b0000, 20,  0, 1, 4, 1, 0);
        vecs[19] = mk(4'b0000, 4'b0111, 20,  0, 1, 7, 1, 0);
        vecs[20] = mk(4'b0000, 4'b0000, 20,  0, 1, 7, 1, 0);
        vecs[21] = mk(4'b0000, 4'b0001, 20,  0, 1, 8, 2, 0);
        vecs[22] = mk(4'b1111, 4'b0001, 20,  0, 1, 8, 2, 0);
        vecs[23] = mk(4'b1111, 4'b0011, 20,  0, 1, 8, 2, 0);

        // Four-lane hits from a fresh game: first level-up lands at score 52.
        lvl[0] = mk(4'b1111, 4'b0000,  4,  4, 1, 0, 1, 0);
        lvl[1] = mk(4'b1111, 4'b0000,  8,  8, 1, 0, 1, 0);
        lvl[2] = mk(4'b1111, 4'b0000, 12, 12, 2, 0, 1, 0);
        lvl[3] = mk(4'b1111, 4'b0000, 20, 16, 2, 0, 1, 0);
        lvl[4] = mk(4'b1111, 4'b0000, 28, 20, 3, 0, 1, 0);
        lvl[5] = mk(4'b1111, 4'b0000, 40, 24, 3, 0, 1, 0);
        lvl[6] = mk(4'b1111, 4'b0000, 52, 28, 3, 0, 1, 20000);
        lvl[7] = mk(4'b1111, 4'b0000, 64, 32, 4, 0, 1, 20000);

        reset = 1'b0; start_switch = 1'b0;
        point_flag = 4'b0000; block_gone_flag = 4'b0000;
        step(4'b0000, 4'b0000);
        step(4'b0000, 4'b0000);
        check_all("reset", 0, 0, 1, 0, 0, 0);

        reset = 1'b1;
        start_switch = 1'b1;
        step(4'b0000, 4'b0000);
        check_all("start", 0, 0, 1, 0, 1, 0);

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].pf, vecs[i].bg);
            check_all($sformatf("vec%0d", i), vecs[i].score, vecs[i].combo, vecs[i].mult,
                      vecs[i].miss, vecs[i].st, vecs[i].speed);
        end

        // Sticky miss levels held for 100 cycles add no further misses.
        for (int i = 0; i < 100; i++) step(4'b0000, 4'b0101);
        check_all("sticky_hold", 20, 0, 1, 2, 1, 0);

        for (int i = 14; i < 24; i++) begin
            step(vecs[i].pf, vecs[i].bg);
            check_all($sformatf("vec%0d", i), vecs[i].score, vecs[i].combo, vecs[i].mult,
                      vecs[i].miss, vecs[i].st, vecs[i].speed);
        end

        // OVER -> TITLE keeps counters; a flag high before PLAY is not a miss.
        start_switch = 1'b0;
        step(4'b0000, 4'b0000);
        check_all("over_to_title", 20, 0, 1, 8, 0, 0);
        step(4'b0000, 4'b0001);
        start_switch = 1'b1;
        step(4'b0000, 4'b0001);
        check_all("restart", 0, 0, 1, 0, 1, 0);
        step(4'b0000, 4'b0001);
        check_all("stale_flag", 0, 0, 1, 0, 1, 0);
        step(4'b0000, 4'b0000);

        for (int i = 0; i < 8; i++) begin
            step(lvl[i].pf, lvl[i].bg);
            check_all($sformatf("lvl%0d", i), lvl[i].score, lvl[i].combo, lvl[i].mult,
                      lvl[i].miss, lvl[i].st, lvl[i].speed);
        end

        // At multiplier 4 each four-lane cycle adds 16 points.
        for (int i = 0; i < 27; i++) step(4'b1111, 4'b0000);
        check_all("lvl_496", 496, 140, 4, 0, 1, 180000);
        step(4'b1111, 4'b0000);
        check_all("lvl_512", 512, 144, 4, 0, 1, 200000);
        for (int i = 0; i < 20; i++) step(4'b1111, 4'b0000);
        check_all("speed_clamp", 832, 224, 4, 0, 1, 200000);

        for (int i = 0; i < 4043; i++) step(4'b1111, 4'b0000);
        check_all("near_sat", 65520, 255, 4, 0, 1, 200000);
        step(4'b1111, 4'b0000);
        check_all("score_sat", 65535, 255, 4, 0, 1, 200000);
        step(4'b1111, 4'b0000);
        check_all("score_stick", 65535, 255, 4, 0, 1, 200000);

        // Abort mid-PLAY holds counters; re-entering PLAY clears them.
        start_switch = 1'b0;
        step(4'b0000, 4'b0000);
        check_all("abort", 65535, 255, 4, 0, 0, 200000);
        start_switch = 1'b1;
        step(4'b0000, 4'b0000);
        check_all("reenter", 0, 0, 1, 0, 1, 0);

        // Reset mid-game returns to TITLE even with start_switch high.
        step(4'b1111, 4'b0000);
        check_all("pre_reset", 4, 4, 1, 0, 1, 0);
        reset = 1'b0;
        step(4'b1111, 4'b0000);
        check_all("mid_reset", 0, 0, 1, 0, 0, 0);
        reset = 1'b1;
        step(4'b0000, 4'b0000);
        check_all("post_reset", 0, 0, 1, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_tracker.md
Name: score_tracker

Overview:
- Downstream consumer of the per-lane note blocks. It takes each lane's one-cycle hit pulse (pointFlag) and its sticky miss level (blockgoneflag), and keeps score, combo, multiplier, miss count and game state.
- Drives the shared speed_shift bus back into every block's speedshiftIn, so difficulty ramps with points earned.
- Output feeds the score/HUD renderer and the top-level game FSM.

Parameters:
- NUM_LANES, 4, number of note lanes / block instances
- SCORE_W, 16, score width; score saturates
- COMBO_W, 8, combo counter width; combo saturates
- MULT_STEP, 10, combo hits per multiplier increment
- MAX_MULT, 4, multiplier ceiling
- MAX_MISSES, 8, misses that end the game
- LEVEL_POINTS, 50, score delta per difficulty step
- SPEED_STEP, 20000, speed_shift increment per level
- SPEED_MAX, 200000, speed_shift ceiling (must stay below 250000)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start_switch  in  1  game start switch (level)
- point_flag  in  NUM_LANES  per-lane hit pulse, one cycle wide
- block_gone_flag  in  NUM_LANES  per-lane miss flag, sticky level
- game_state  out  2  00 TITLE, 01 PLAY, 10 OVER
- score  out  SCORE_W  accumulated points
- combo  out  COMBO_W  consecutive hits since the last miss
- multiplier  out  3  current point multiplier, 1..MAX_MULT
- miss_count  out  4  misses this game
- game_over  out  1  high while in OVER
- speed_shift  out  50  difficulty offset to the blocks' speedshiftIn

Behaviour:
- Reset (reset==0 at a clk edge):
  - game_state=TITLE, score=0, combo=0, multiplier=1, miss_count=0, game_over=0, speed_shift=0.
  - Edge-detect history registers are cleared to 0.
- Miss events:
  - miss_evt[i] = block_gone_flag[i] & ~prev_gone[i], one per rising edge of the sticky flag.
  - prev_gone is updated every cycle in every state, so a flag already high when PLAY starts is not counted.
- Hit events: hit_evt = point_flag, used directly.
- hits = popcount(hit_evt); misses = popcount(miss_evt). Both are 0..NUM_LANES.
- TITLE:
  - start_switch==1 moves to PLAY next cycle.
  - On that transition, score, combo, miss_count and speed_shift clear, and multiplier=1.
- PLAY, one-cycle latency: outputs reflect a cycle's events on the next edge.
  - score_next = sat(score + hits*multiplier), where multiplier is the pre-update registered value.
  - If misses>0: combo_next=0 and multiplier_next=1, even if hits>0 in the same cycle.
  - If misses==0: combo_next = sat(combo+hits) at 2^COMBO_W-1.
  - multiplier_next = min(MAX_MULT, 1 + combo_next/MULT_STEP).
  - miss_count_next = miss_count + misses, saturating at 15.
  - If miss_count_next >= MAX_MISSES, move to OVER.
  - Level tracking:
    - An internal level_acc counts points since the last level-up.
    - When level_acc + awarded >= LEVEL_POINTS: speed_shift += SPEED_STEP, clamped at SPEED_MAX, and level_acc = level_acc + awarded - LEVEL_POINTS.
    - Only one level-up is allowed per cycle.
  - start_switch==0 aborts to TITLE. Counters hold their values until the next TITLE->PLAY transition.
- OVER:
  - game_over=1. All events are ignored and score is frozen.
  - start_switch==0 moves to TITLE; start_switch==1 holds in OVER.
- Saturation: score sticks at 2^SCORE_W-1; overflow never wraps.
- Reset mid-game: everything returns to reset values the same cycle. The next PLAY entry still requires start_switch.

Decomposition:
- Shared package game_pkg holds:
  - the game_state encoding constants (TITLE/PLAY/OVER);
  - the default MAX_MISSES, MULT_STEP and speed constants, which the blocks use too.
- One sub-module, lane_event_counter:
  - per-lane rising-edge detect of block_gone_flag;
  - popcount of hits and misses;
  - parameterised by NUM_LANES, purely registered edge history plus combinational counts.

Test Plan:
- Reset low for 2 cycles, then start_switch=1 -> game_state=01 one cycle later; score=0, multiplier=1, speed_shift=0.
- 10 single-lane hits on separate cycles -> score=10, combo=10, multiplier=2. The 11th hit -> score=12.
- point_flag=4'b1111 in one cycle with multiplier=1 -> score +4, combo +4. The same cycle with block_gone_flag[2] rising -> combo=0, multiplier=1, score still +4, miss_count +1.
- Hold block_gone_flag[0] high for 100 cycles -> miss_count increments exactly once. 8 distinct rising edges -> game_state=10, game_over=1, and further hits leave score unchanged.
- Accumulate 50 points -> speed_shift=20000. Accumulate 500 points -> speed_shift=200000, and it stays there (clamp).
- Preload score to 65534, then one hit at multiplier 4 -> score=65535 (saturates). Drop start_switch mid-PLAY -> TITLE; raise it again -> counters cleared.
